// File: rtl/ram_sp_clr.sv
// Single-port byte-enabled RAM with a registered, write-through read port.
// Reset or a clr pulse triggers a one-word-per-cycle zeroing sweep.
module ram_sp_clr #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ce,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     data_in,
   input  logic                  clr,
   output logic [DATA_W-1:0]     data_out,
   output logic                  valid,
   output logic                  busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int NB    = DATA_W / 8;

   // Handshake: no backpressure. A request is accepted on any rising edge where
   // busy=0, ce=1 and clr=0; read data returns the next cycle with valid=1 for
   // exactly one cycle. While busy=1 every request is silently dropped.
   typedef enum logic {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W:0]     r_cnt;
   logic [ADDR_W:0]     w_cnt_nxt;
   logic [ADDR_W:0]     w_cnt_inc;
   logic                w_sweep_done;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_data_out;
   logic                r_valid;
   logic [DATA_W-1:0]   w_rd_word;
   logic [DATA_W-1:0]   w_merged;
   logic                w_req_ok;
   logic                w_do_wr;
   logic                w_do_rd;

   always_comb begin
      w_req_ok  = (r_state == S_IDLE) && ce && !clr;
      w_do_wr   = w_req_ok && wr_en;
      w_do_rd   = w_req_ok && rd_en;
      w_rd_word = r_mem[addr];
      // Merged word is both the write value and the write-through read value.
      w_merged  = w_rd_word;
      for (int k = 0; k < NB; k++) begin
         if (wr_en && be[k]) begin
            w_merged[8*k +: 8] = data_in[8*k +: 8];
         end
      end
   end

   // Extra counter bit flags the last sweep word without a separate compare.
   always_comb begin
      w_cnt_inc    = r_cnt + 1'b1;
      w_sweep_done = w_cnt_inc[ADDR_W];
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_CLEAR: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_sweep_done) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         S_IDLE: begin
            if (clr) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_CLEAR;
         r_cnt      <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_valid    <= w_do_rd;
         r_data_out <= w_do_rd ? w_merged : '0;
      end
   end

   // Array has no reset; the sweep is the only zeroing path.
   always_ff @(posedge clk) begin
      if (r_state == S_CLEAR) begin
         r_mem[r_cnt[ADDR_W-1:0]] <= '0;
      end else if (w_do_wr) begin
         r_mem[addr] <= w_merged;
      end
   end

   assign data_out = r_data_out;
   assign valid    = r_valid;
   assign busy     = (r_state == S_CLEAR);

endmodule

// File: tb/tb_ram_sp_clr.sv
// Bench for ram_sp_clr (DATA_W=16, ADDR_W=4): directed scenarios plus random
// traffic, all checked against an array-based model of the RAM and its sweep.
module tb_ram_sp_clr;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    be = '0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          clr = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          busy;

  ram_sp_clr #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .rd_en(rd_en), .wr_en(wr_en),
    .be(be), .addr(addr), .data_in(data_in), .clr(clr),
    .data_out(data_out), .valid(valid), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: word array plus number of sweep cycles still owed
  logic [DW-1:0] m_mem [DEPTH];
  int            sweep_left;
  logic [DW-1:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, check outputs #1 after the edge.
  task automatic step(input logic ce_i, input logic rd_i, input logic wr_i,
                      input logic clr_i, input logic [1:0] be_i,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic exp_v;
    ce = ce_i; rd_en = rd_i; wr_en = wr_i; clr = clr_i;
    be = be_i; addr = a; data_in = d;
    @(posedge clk);
    exp_v = 1'b0;
    if (sweep_left > 0) begin
      m_mem[DEPTH - sweep_left] = '0;
      sweep_left--;
    end else if (clr_i) begin
      sweep_left = DEPTH;
    end else if (ce_i) begin
      if (wr_i) begin
        for (int k = 0; k < 2; k++)
          if (be_i[k]) m_mem[a][8*k +: 8] = d[8*k +: 8];
      end
      if (rd_i) begin
        exp_v = 1'b1;
        exp_q.push_back(m_mem[a]);
      end
    end
    #1;
    check("busy", {31'd0, busy}, {31'd0, sweep_left > 0});
    check("valid", {31'd0, valid}, {31'd0, exp_v});
    if (exp_v) check("rdata", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
    else       check("idle_data", {16'd0, data_out}, 32'd0);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
  endtask

  // Called #1 after an edge; holds reset over two edges, releases #1 after the last.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    sweep_left = DEPTH;
    exp_q.delete();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_data", {16'd0, data_out}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic sweep_and_count(input string tag);
    int cycles;
    cycles = 0;
    while (busy && cycles < 40) begin
      idle_step();
      cycles++;
    end
    check(tag, cycles, DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    sweep_left = DEPTH;
    @(posedge clk);
    #1;
    do_reset();

    // power-on sweep takes exactly DEPTH cycles, then everything reads zero
    sweep_and_count("por_sweep_len");
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, AW'(i), '0);
    idle_step();

    // full write, read back, then idle returns to zero
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 4'd5, 16'hA5C3);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, 16'h0000);
    check("rd5_const", {16'd0, data_out}, 32'h0000_A5C3);
    idle_step();
    check("rd5_after_idle", {31'd0, valid}, 32'd0);

    // partial byte write
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 4'd7, 16'h1234);
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 4'd7, 16'hFFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 4'd7, 16'h0000);
    check("rd7_const", {16'd0, data_out}, 32'h0000_12FF);

    // write-through with upper byte only
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 4'd3, 16'h0011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 4'd3, 16'hBEEF);
    check("wt3_const", {16'd0, data_out}, 32'h0000_BE11);

    // back-to-back reads
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, AW'(i + 2), '0);

    // fill all words, clear, hammer requests while busy, then verify zeros
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, AW'(i), 16'h1000 + 16'(i) + 16'h0101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 4'd9, 16'hDEAD);
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 1'b1, 1'(i % 3 == 0), 2'b11, AW'($urandom_range(0, 15)), 16'(($urandom)));
    check("clr_done", {31'd0, busy}, 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, AW'(i), '0);

    // reset at sweep cycle 8 restarts a full sweep
    step(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, '0, '0);
    for (int i = 0; i < 8; i++) idle_step();
    do_reset();
    sweep_and_count("mid_rst_sweep_len");
    step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5, '0);
    check("ce0_valid", {31'd0, valid}, 32'd0);

    // reset while a read is in flight: no valid may appear
    step(1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 4'd1, 16'h5A5A);
    ce = 1'b1; rd_en = 1'b1; wr_en = 1'b0; clr = 1'b0; addr = 4'd1;
    @(negedge clk);
    do_reset();
    check("inflight_valid", {31'd0, valid}, 32'd0);
    sweep_and_count("inflight_sweep_len");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 49) == 0),
             2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), 16'($urandom));
      end
    end
    while (sweep_left > 0) idle_step();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, AW'(i), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_sp_clr.md
RAM_SP_CLR -- requirements
Module: ram_sp_clr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8: data width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 4: address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port ce, input, 1 bit: chip enable; no operation when low.
REQ-006 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port be, input, DATA_W/8 bits: byte enables for writes; bit k gates data_in[8k+7:8k].
REQ-009 The block SHALL have port addr, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-011 The block SHALL have port clr, input, 1 bit: single-cycle request to zero the whole array.
REQ-012 The block SHALL have port data_out, output, DATA_W bits: registered read data.
REQ-013 The block SHALL have port valid, output, 1 bit: data_out holds read data this cycle.
REQ-014 The block SHALL have port busy, output, 1 bit: clear sweep in progress; requests are ignored.

Function
REQ-015 The FSM SHALL have two states, CLEAR and IDLE.
REQ-016 CLEAR SHALL write zero to one word per cycle, from address 0 to DEPTH-1 in ascending order, taking exactly DEPTH cycles, then go to IDLE.
REQ-017 busy SHALL be 1 in CLEAR and 0 in IDLE.
REQ-018 In IDLE, a sampled clr=1 SHALL enter CLEAR with the sweep counter at 0, regardless of ce/rd_en/wr_en that cycle; the rd/wr request that cycle SHALL be dropped.
REQ-019 clr SHALL be ignored while in CLEAR.
REQ-020 ce, rd_en and wr_en SHALL be ignored while busy=1; valid SHALL stay 0.
REQ-021 Write: in IDLE with ce=1, wr_en=1 and clr=0, each byte of mem[addr] with be[k]=1 SHALL take data_in; bytes with be[k]=0 SHALL be unchanged.
REQ-022 Read: in IDLE with ce=1, rd_en=1, wr_en=0 and clr=0, data_out SHALL equal mem[addr] and valid SHALL be 1 in the following cycle (latency 1), for that one cycle only.
REQ-023 Simultaneous rd_en=1 and wr_en=1 SHALL perform the write and return the post-write (merged) word of mem[addr] next cycle with valid=1 (write-through).
REQ-024 Back-to-back reads SHALL give valid=1 on consecutive cycles, with no bubble.
REQ-025 In any cycle after an edge with no read, data_out SHALL be 0 and valid SHALL be 0.
REQ-026 A write immediately followed by a read of the same address SHALL return the new data.
REQ-027 Addresses SHALL be full-range with no out-of-range case; the sweep counter SHALL be ADDR_W+1 bits to detect completion.

Reset
REQ-028 When rst_n=0, asynchronously: data_out=0, valid=0, sweep counter=0, state=CLEAR, busy=1.
REQ-029 On rst_n release, the block SHALL perform a full DEPTH-cycle clear sweep before accepting requests.
REQ-030 Reset asserted mid-sweep or mid-read SHALL restart the sweep from address 0; a read in flight SHALL produce no valid.
REQ-031 Array contents SHALL NOT be reset asynchronously; zeroing happens only through the sweep.

Verification (DATA_W=16, ADDR_W=4)
REQ-032 Release reset -> busy=1 for exactly 16 cycles, then busy=0; reading addr 0..15 returns 16'h0000 with valid=1 each.
REQ-033 Write addr 5 = 16'hA5C3, be=2'b11; next cycle read addr 5 -> data_out=16'hA5C3, valid=1; next idle cycle -> data_out=0, valid=0.
REQ-034 Write addr 7 = 16'h1234, then write addr 7 = 16'hFFFF with be=2'b01; read -> 16'h12FF.
REQ-035 rd_en=wr_en=1, addr 3, data_in=16'hBEEF, be=2'b10, prior 16'h0011 -> next cycle data_out=16'hBE11, valid=1.
REQ-036 Pulse clr after filling addr 0..15 with nonzero data; drive reads and writes during busy -> no valid for 16 cycles, no writes land; after the sweep, all words read 16'h0000.
REQ-037 Assert rst_n=0 at sweep cycle 8, release -> busy=1 for a full 16 cycles again; ce=0 with rd_en=1 -> valid=0, data_out=0.
